requant_lrelu_pipe: RTL and testbench

REQUANT_LRELU_PIPE -- requirements
Module: requant_lrelu_pipe

---
 rtl/requant_pkg.sv | 45 ++++
 rtl/requant_lane.sv | 86 ++++++++
 rtl/requant_lrelu_pipe.sv | 118 +++++++++++
 tb/tb_requant_lrelu_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared constants and arithmetic helpers for the requantize + leaky-ReLU pipe.
package requant_pkg;

    // Config register addresses
    localparam logic [2:0] CFG_POS_MULT  = 3'd0;
    localparam logic [2:0] CFG_POS_SHIFT = 3'd1;
    localparam logic [2:0] CFG_NEG_MULT  = 3'd2;
    localparam logic [2:0] CFG_NEG_SHIFT = 3'd3;
    localparam logic [2:0] CFG_IN_OFF    = 3'd4;
    localparam logic [2:0] CFG_OUT_OFF   = 3'd5;
    localparam logic [2:0] CFG_OUT_MIN   = 3'd6;
    localparam logic [2:0] CFG_OUT_MAX   = 3'd7;

    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

    // SRDHM rounding nudges: 2^30 and 1-2^30
    localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
    localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

    // Second half of SRDHM: nudge the 64-bit product and divide by 2^31 toward zero.
    // The single overflowing case (MIN*MIN) is flagged by the caller.
    function automatic logic signed [31:0] srdhm_fin(input logic signed [63:0] prod,
                                                     input logic sat);
        logic signed [63:0] s;
        logic signed [63:0] q;
        s = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
        // Arithmetic shift floors; bias negatives so the result truncates toward zero
        q = s[63] ? ((s + 64'sh0000_0000_7FFF_FFFF) >>> 31) : (s >>> 31);
        return sat ? INT32_MAX : q[31:0];
    endfunction

    // Rounding right shift, ties away from zero
    function automatic logic signed [31:0] rshift_rnd(input logic signed [31:0] x,
                                                      input logic [4:0] sh);
        logic [31:0] mask;
        logic [31:0] rem;
        logic [31:0] thr;
        mask = (32'd1 << sh) - 32'd1;
        rem  = x & mask;
        thr  = (mask >> 1) + {31'd0, x[31]};
        return (x >>> sh) + ((rem > thr) ? 32'sd1 : 32'sd0);
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One-lane 3-stage requantize datapath. Stage registers advance together on i_en;
// the handshake and config storage live in the parent.
module requant_lane
    import requant_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic signed [31:0] i_acc,
    input  logic signed [31:0] i_in_offset,
    input  logic signed [31:0] i_pos_mult,
    input  logic        [5:0]  i_pos_shift,
    input  logic signed [31:0] i_neg_mult,
    input  logic        [5:0]  i_neg_shift,
    input  logic signed [31:0] i_out_offset,
    input  logic signed [31:0] i_out_min,
    input  logic signed [31:0] i_out_max,
    output logic [OUT_W-1:0]   o_res
);

    logic signed [31:0] w_x;
    logic signed [31:0] w_mult;
    logic        [5:0]  w_sh;
    logic        [5:0]  w_nsh;
    logic        [4:0]  w_lsh;
    logic        [4:0]  w_rsh;
    logic signed [31:0] w_q;
    logic signed [31:0] w_r;
    logic signed [32:0] w_y;
    logic signed [31:0] w_c;

    logic signed [31:0] r_s1_x;
    logic signed [31:0] r_s1_mult;
    logic        [4:0]  r_s1_rsh;
    logic signed [63:0] r_s2_prod;
    logic               r_s2_sat;
    logic        [4:0]  r_s2_rsh;
    logic [OUT_W-1:0]   r_out;

    // S1: offset, pick branch by sign, split signed shift into left/right amounts
    always_comb begin
        w_x    = i_acc - i_in_offset;
        w_mult = w_x[31] ? i_neg_mult  : i_pos_mult;
        w_sh   = w_x[31] ? i_neg_shift : i_pos_shift;
        w_nsh  = 6'd0 - w_sh;
        w_lsh  = w_sh[5] ? 5'd0 : w_sh[4:0];
        // -(-32) does not fit in 5 bits; saturate it to 31
        w_rsh  = !w_sh[5] ? 5'd0 : (w_nsh[5] ? 5'd31 : w_nsh[4:0]);
    end

    // S3: SRDHM, rounding shift, output offset and clamp
    always_comb begin
        w_q = srdhm_fin(r_s2_prod, r_s2_sat);
        w_r = rshift_rnd(w_q, r_s2_rsh);
        w_y = 33'(w_r) + 33'(i_out_offset);
        if (w_y < 33'(i_out_min))      w_c = i_out_min;
        else if (w_y > 33'(i_out_max)) w_c = i_out_max;
        else                           w_c = w_y[31:0];
    end

    // Stage registers; all move on the shared enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_x    <= '0;
            r_s1_mult <= '0;
            r_s1_rsh  <= '0;
            r_s2_prod <= '0;
            r_s2_sat  <= 1'b0;
            r_s2_rsh  <= '0;
            r_out     <= '0;
        end else if (i_en) begin
            r_s1_x    <= w_x <<< w_lsh;
            r_s1_mult <= w_mult;
            r_s1_rsh  <= w_rsh;
            r_s2_prod <= 64'(r_s1_x) * 64'(r_s1_mult);
            r_s2_sat  <= (r_s1_x == INT32_MIN) && (r_s1_mult == INT32_MIN);
            r_s2_rsh  <= r_s1_rsh;
            r_out     <= w_c[OUT_W-1:0];
        end
    end

    assign o_res = r_out;

endmodule

// File: rtl/requant_lrelu_pipe.sv
// Multi-lane requantize + leaky-ReLU pipeline: handshake, stage valids, config regs.
// Optional feature macro: LRELU_NEG_PATH_EN -- separate multiplier/shift for x<0.
// Without it, registers 2/3 are unimplemented and every x uses the positive set.
module requant_lrelu_pipe
    import requant_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_data,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*32-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   busy
);

    localparam logic signed [31:0] OMIN_RST = -(32'sd1 <<< (OUT_W-1));
    localparam logic signed [31:0] OMAX_RST = (32'sd1 <<< (OUT_W-1)) - 32'sd1;

    logic [3:1]         r_vld_pipe;
    logic               r_cfg_err;
    logic signed [31:0] r_pos_mult;
    logic        [5:0]  r_pos_shift;
    logic signed [31:0] r_in_off;
    logic signed [31:0] r_out_off;
    logic signed [31:0] r_out_min;
    logic signed [31:0] r_out_max;
    logic signed [31:0] w_neg_mult;
    logic        [5:0]  w_neg_shift;
    logic               w_adv;

    assign w_adv     = out_ready | ~r_vld_pipe[3];
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[3];
    assign busy      = |r_vld_pipe;
    assign cfg_err   = r_cfg_err;

`ifdef LRELU_NEG_PATH_EN
    logic signed [31:0] r_neg_mult;
    logic        [5:0]  r_neg_shift;

    // Negative-branch parameters, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_mult  <= '0;
            r_neg_shift <= '0;
        end else if (cfg_we && !busy && !in_valid) begin
            if (cfg_addr == CFG_NEG_MULT)  r_neg_mult  <= cfg_data;
            if (cfg_addr == CFG_NEG_SHIFT) r_neg_shift <= cfg_data[5:0];
        end
    end

    assign w_neg_mult  = r_neg_mult;
    assign w_neg_shift = r_neg_shift;
`else
    assign w_neg_mult  = r_pos_mult;
    assign w_neg_shift = r_pos_shift;
`endif

    // Config writes land only on an idle pipe so in-flight beats see stable params
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_err   <= 1'b0;
            r_pos_mult  <= '0;
            r_pos_shift <= '0;
            r_in_off    <= '0;
            r_out_off   <= '0;
            r_out_min   <= OMIN_RST;
            r_out_max   <= OMAX_RST;
        end else begin
            r_cfg_err <= cfg_we & (busy | in_valid);
            if (cfg_we && !busy && !in_valid) begin
                case (cfg_addr)
                    CFG_POS_MULT:  r_pos_mult  <= cfg_data;
                    CFG_POS_SHIFT: r_pos_shift <= cfg_data[5:0];
                    CFG_IN_OFF:    r_in_off    <= cfg_data;
                    CFG_OUT_OFF:   r_out_off   <= cfg_data;
                    CFG_OUT_MIN:   r_out_min   <= cfg_data;
                    CFG_OUT_MAX:   r_out_max   <= cfg_data;
                    default: ;
                endcase
            end
        end
    end

    // Stage valids shift together with the lane datapaths
    always_ff @(posedge clk) begin
        if (reset)      r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        requant_lane #(.OUT_W(OUT_W)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .i_en         (w_adv),
            .i_acc        (in_data[l*32 +: 32]),
            .i_in_offset  (r_in_off),
            .i_pos_mult   (r_pos_mult),
            .i_pos_shift  (r_pos_shift),
            .i_neg_mult   (w_neg_mult),
            .i_neg_shift  (w_neg_shift),
            .i_out_offset (r_out_off),
            .i_out_min    (r_out_min),
            .i_out_max    (r_out_max),
            .o_res        (out_data[l*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_requant_lrelu_pipe.sv
// Directed bench for requant_lrelu_pipe (LANES=4, OUT_W=8), expected values hand-computed.
module tb_requant_lrelu_pipe;
    import requant_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic         cfg_err;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    requant_lrelu_pipe #(.LANES(4), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [127:0] pi4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d, output logic err);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    // One beat into an idle pipe with out_ready high: check latency and result
    task automatic beat(input logic [127:0] d, input logic [31:0] e, input string tag);
        int lat;
        in_data = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk(tag, 64'(out_data), 64'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        logic err;
        logic dropped;
        logic stall_prev;
        logic acc_in;
        logic acc_out;
        logic [31:0] held;
        int sent;
        int rcv;
        int stale;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_cfg_err",   64'(cfg_err),   64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic positive path and clamp
        cfg_wr(CFG_POS_MULT, 32'h4000_0000, err);
        chk("cfg_pm_err", 64'(err), 64'd0);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(100, 101, 0, -300), pk4(50, 51, 0, 0), "beatA");
`else
        beat(pi4(100, 101, 0, -300), pk4(50, 51, 0, -128), "beatA");
`endif

        // Streaming with backpressure on cycles 2..7
        sent = 0; rcv = 0; dropped = 1'b0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 7);
            in_valid  = (sent < 6);
            in_data   = pi4(8*sent, 8*sent+2, 8*sent+4, 8*sent+6);
            #1;
            acc_in  = in_valid & in_ready;
            acc_out = out_valid & out_ready;
            if (in_valid && !in_ready) dropped = 1'b1;
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold",  64'(out_data),  64'(held));
            end
            stall_prev = out_valid & ~out_ready;
            held = out_data;
            if (acc_out) begin
                chk($sformatf("strm%0d", rcv), 64'(out_data), 64'(pk4(4*rcv, 4*rcv+1, 4*rcv+2, 4*rcv+3)));
                rcv++;
            end
            @(posedge clk); #1;
            if (acc_in) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("strm_count",    64'(rcv),     64'd6);
        chk("strm_in_ready", 64'(dropped), 64'd1);
        repeat (4) @(posedge clk);
        #1;

        // Config write while busy is rejected
        in_data = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_set", 64'(busy), 64'd1);
        cfg_wr(CFG_IN_OFF, 32'd100, err);
        chk("cfg_err_pulse", 64'(err), 64'd1);
        @(posedge clk); #1;
        chk("cfg_err_once", 64'(cfg_err), 64'd0);
        for (int i = 0; i < 10 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_clear", 64'(busy), 64'd0);
        beat(pi4(100, 102, 0, 0), pk4(50, 51, 0, 0), "rejected_unchanged");

        // Same write on an idle pipe is applied
        cfg_wr(CFG_IN_OFF, 32'd100, err);
        chk("cfg_ok_no_err", 64'(err), 64'd0);
        cfg_wr(CFG_OUT_OFF, 32'd5, err);
        cfg_wr(CFG_OUT_MIN, -32'sd20, err);
        cfg_wr(CFG_OUT_MAX, 32'd20, err);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(100, 120, 200, 60), pk4(5, 15, 20, 5), "offsets");
`else
        beat(pi4(100, 120, 200, 60), pk4(5, 15, 20, -15), "offsets");
`endif

        // Reset with three beats in flight
        in_data = pi4(300, 300, 300, 300); in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_out_data",  64'(out_data),  64'd0);
        reset = 1'b0;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("midrst_stale", 64'(stale), 64'd0);
        cfg_wr(CFG_POS_MULT, 32'h7FFF_FFFF, err);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(1000, -1000, 5, 0), pk4(127, 0, 5, 0), "minmax_reset");
`else
        beat(pi4(1000, -1000, 5, 0), pk4(127, -128, 5, 0), "minmax_reset");
`endif

        // Negative branch parameters
        cfg_wr(CFG_POS_MULT, 32'h4000_0000, err);
        cfg_wr(CFG_NEG_MULT, 32'h0CCC_CCCD, err);
        chk("neg_mult_err", 64'(err), 64'd0);
        cfg_wr(CFG_NEG_SHIFT, 32'd0, err);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(-50, -50, 100, 0), pk4(-5, -5, 50, 0), "neg_path");
`else
        beat(pi4(-50, -50, 100, 0), pk4(-25, -25, 50, 0), "neg_path");
`endif

        // Right shift by 1 with round-half-away
        cfg_wr(CFG_POS_SHIFT, 32'h0000_003F, err);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(6, -6, 0, 7), pk4(2, -1, 0, 2), "rshift");
`else
        beat(pi4(6, -6, 0, 7), pk4(2, -2, 0, 2), "rshift");
`endif

        // Left shift by 2, including 32-bit wrap to INT32_MIN
        cfg_wr(CFG_POS_SHIFT, 32'd2, err);
`ifdef LRELU_NEG_PATH_EN
        beat(pi4(10, 32'h2000_0000, 1, -1), pk4(20, -128, 2, 0), "lshift");
`else
        beat(pi4(10, 32'h2000_0000, 1, -1), pk4(20, -128, 2, -2), "lshift");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
